// File: rtl/mac_operand_feeder.sv
// mac_operand_feeder: packs an 8-bit byte stream into the X/Y operands, issues one MAC start
// and returns the MAC result, or a timeout error, on a valid/ready result port. Rev 1.0
`default_nettype none

module mac_operand_feeder #(
  parameter int ELEMS   = 4,
  parameter int OUTW    = 20,
  parameter int TIMEOUT = 64
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  input  logic [7:0]         in_data_i,
  output logic               in_ready_o,
  output logic [ELEMS*8-1:0] mac_x_o,
  output logic [ELEMS*8-1:0] mac_y_o,
  output logic               mac_start_o,
  input  logic               mac_ready_i,
  input  logic [OUTW-1:0]    mac_out_i,
  output logic               res_valid_o,
  output logic [OUTW-1:0]    res_data_o,
  output logic               res_err_o,
  input  logic               res_ready_i
);

  localparam int XW     = ELEMS * 8;
  localparam int NBYTES = 2 * ELEMS;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  C_LAST_BYTE = CNT_W'(NBYTES - 1);
  localparam logic [TCNT_W-1:0] C_TLIMIT    = TCNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_LOAD      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RESULT    = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [2*XW-1:0]     ops_q, ops_d;
  logic [OUTW-1:0]     res_data_q, res_data_d;
  logic                res_err_q, res_err_d;
  logic                in_ready_q;
  logic                accept;
  logic                timeout;
  logic                in_tphase;

  // in_ready_q is only ever high while the state register holds S_LOAD
  assign accept    = in_valid_i & in_ready_q;
  assign timeout   = (tcnt_q == C_TLIMIT);
  assign in_tphase = (state_q == S_START) || (state_q == S_WAIT_BUSY) ||
                     (state_q == S_WAIT_DONE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tcnt_d      = tcnt_q;
    ops_d       = ops_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    mac_start_o = 1'b0;

    if (in_tphase && !timeout) begin
      tcnt_d = tcnt_q + TCNT_W'(1);
    end

    case (state_q)
      S_LOAD: begin
        if (accept) begin
          ops_d[int'(cnt_q)*8 +: 8] = in_data_i;
          if (cnt_q == C_LAST_BYTE) begin
            state_d = S_START;
            cnt_d   = '0;
            tcnt_d  = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_START: begin
        // An expiring budget suppresses the pulse so no MAC op is left orphaned
        if (timeout) begin
          state_d    = S_RESULT;
          res_err_d  = 1'b1;
          res_data_d = '0;
        end else if (mac_ready_i) begin
          mac_start_o = 1'b1;
          state_d     = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (timeout) begin
          state_d    = S_RESULT;
          res_err_d  = 1'b1;
          res_data_d = '0;
        end else if (!mac_ready_i) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (mac_ready_i) begin
          state_d    = S_RESULT;
          res_err_d  = 1'b0;
          res_data_d = mac_out_i;
        end else if (timeout) begin
          state_d    = S_RESULT;
          res_err_d  = 1'b1;
          res_data_d = '0;
        end
      end
      S_RESULT: begin
        if (res_ready_i) begin
          state_d   = S_LOAD;
          res_err_d = 1'b0;
          cnt_d     = '0;
        end
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_LOAD;
      cnt_q      <= '0;
      tcnt_q     <= '0;
      ops_q      <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tcnt_q     <= tcnt_d;
      ops_q      <= ops_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
      in_ready_q <= (state_d == S_LOAD);
    end
  end

  assign in_ready_o  = in_ready_q;
  assign mac_x_o     = ops_q[XW-1:0];
  assign mac_y_o     = ops_q[2*XW-1:XW];
  assign res_valid_o = (state_q == S_RESULT);
  assign res_data_o  = res_data_q;
  assign res_err_o   = res_err_q;

endmodule

`default_nettype wire
